// File: rtl/adder_share_sequencer.sv
// Shares one WIDTH-bit adder between two round-robin requesters, adding WIDTH*WORDS-bit operands LSW first.
// Optional: define ADD_SEQ_OVERFLOW_EN to add the resp_ovf signed-overflow output.
module adder_share_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [WIDTH*WORDS-1:0] req0_a,
  input  logic [WIDTH*WORDS-1:0] req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [WIDTH*WORDS-1:0] req1_a,
  input  logic [WIDTH*WORDS-1:0] req1_b,
  input  logic                   req1_cin,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH*WORDS-1:0] resp_sum,
  output logic                   resp_cout,
  output logic                   resp_id
`ifdef ADD_SEQ_OVERFLOW_EN
  ,
  output logic                   resp_ovf
`endif
);

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [WORDS-1:0][WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic          cin_reg, carry, cout_reg, id_reg, last_grant;
  logic [KW-1:0] k;
  logic          grant0, grant1, accept;
`ifdef ADD_SEQ_OVERFLOW_EN
  logic          ovf_reg;
`endif

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = rst_n && grant0;
        req1_ready = rst_n && grant1;
        if (grant0 || grant1) state_next = RUN;
      end
      RUN: begin
        add_a   = a_reg[k];
        add_b   = b_reg[k];
        add_cin = (k == '0) ? cin_reg : carry;
        if (k == KLAST) state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = req0_ready || req1_ready;

  // Operands are captured once; the result fills in one word per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      cin_reg    <= 1'b0;
      carry      <= 1'b0;
      cout_reg   <= 1'b0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
      k          <= '0;
`ifdef ADD_SEQ_OVERFLOW_EN
      ovf_reg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg      <= grant1 ? req1_a : req0_a;
            b_reg      <= grant1 ? req1_b : req0_b;
            cin_reg    <= grant1 ? req1_cin : req0_cin;
            id_reg     <= grant1;
            last_grant <= grant1;
            k          <= '0;
          end
        end
        RUN: begin
          sum_reg[k] <= add_sum;
          carry      <= add_cout;
          k          <= k + KW'(1);
          if (k == KLAST) begin
            cout_reg <= add_cout;
`ifdef ADD_SEQ_OVERFLOW_EN
            ovf_reg  <= (a_reg[WORDS-1][WIDTH-1] == b_reg[WORDS-1][WIDTH-1]) &&
                        (add_sum[WIDTH-1] != a_reg[WORDS-1][WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_sum  = sum_reg;
  assign resp_cout = cout_reg;
  assign resp_id   = id_reg;
`ifdef ADD_SEQ_OVERFLOW_EN
  assign resp_ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_adder_share_sequencer.sv
// Randomized self-checking bench for adder_share_sequencer against a plain-arithmetic reference model.
// Define ADD_SEQ_OVERFLOW_EN to also check resp_ovf.
module tb_adder_share_sequencer;
  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int FW    = WIDTH * WORDS;

  typedef logic [FW:0] wide_t;
  typedef struct packed {
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    logic          cin;
  } op_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req0_cin = 1'b0, req1_valid = 1'b0, req1_cin = 1'b0;
  logic             req0_ready, req1_ready;
  logic [FW-1:0]    req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             resp_valid, resp_cout, resp_id;
  logic             resp_ready = 1'b0;
  logic [FW-1:0]    resp_sum;
`ifdef ADD_SEQ_OVERFLOW_EN
  logic             resp_ovf;
`endif

  int total = 0;
  int bad = 0;

  // Requester side: pending operations and what is currently on the bus.
  op_t pend0[$], pend1[$];
  op_t cur0, cur1;
  bit  pres0 = 0, pres1 = 0;
  int  presentPct = 100;
  int  readyMode = 0;

  // Reference model: 0 = idle, 1 = computing word mK, 2 = result pending.
  int    mPhase = 0;
  int    mK = 0;
  bit    mLast = 1;
  bit    mId = 0;
  op_t   mOp;
  wide_t mRes = '0;
  wide_t mLastRes = '0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  adder_share_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout),
    .resp_id(resp_id)
`ifdef ADD_SEQ_OVERFLOW_EN
    , .resp_ovf(resp_ovf)
`endif
  );

  task automatic checkOutput(input string tag, input wide_t obs, input wide_t exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit id, input logic [FW-1:0] a, input logic [FW-1:0] b, input logic cin);
    op_t op;
    op.a = a;
    op.b = b;
    op.cin = cin;
    if (id) pend1.push_back(op);
    else    pend0.push_back(op);
  endtask

  function automatic logic [FW-1:0] randWide();
    logic [FW-1:0] r;
    for (int i = 0; i < WORDS; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom());
    return r;
  endfunction

  // One clock: drive inputs, check every output against the model, then advance the model.
  task automatic stepCycle();
    bit    g0, g1;
    wide_t mask, lowSum;
    @(negedge clk);
    if (!pres0 && pend0.size() > 0 && $urandom_range(99) < presentPct) begin
      cur0 = pend0.pop_front();
      pres0 = 1;
    end
    if (!pres1 && pend1.size() > 0 && $urandom_range(99) < presentPct) begin
      cur1 = pend1.pop_front();
      pres1 = 1;
    end
    req0_valid = pres0;
    req0_a = pres0 ? cur0.a : randWide();
    req0_b = pres0 ? cur0.b : randWide();
    req0_cin = pres0 ? cur0.cin : 1'($urandom_range(1));
    req1_valid = pres1;
    req1_a = pres1 ? cur1.a : randWide();
    req1_b = pres1 ? cur1.b : randWide();
    req1_cin = pres1 ? cur1.cin : 1'($urandom_range(1));
    resp_ready = (readyMode == 0) ? 1'b1 : (readyMode == 1) ? 1'($urandom_range(1)) : 1'b0;
    #1;
    g0 = (mPhase == 0) && pres0 && (!pres1 || mLast);
    g1 = (mPhase == 0) && pres1 && (!pres0 || !mLast);
    checkOutput("req0_ready", req0_ready, g0);
    checkOutput("req1_ready", req1_ready, g1);
    checkOutput("resp_valid", resp_valid, mPhase == 2);
    if (mPhase == 1) begin
      mask = (wide_t'(1) << (mK * WIDTH)) - wide_t'(1);
      lowSum = ({1'b0, mOp.a} & mask) + ({1'b0, mOp.b} & mask) + wide_t'(mOp.cin);
      checkOutput("add_a", add_a, mOp.a[mK*WIDTH +: WIDTH]);
      checkOutput("add_b", add_b, mOp.b[mK*WIDTH +: WIDTH]);
      checkOutput("add_cin", add_cin, lowSum[mK*WIDTH]);
    end else begin
      checkOutput("add_a_idle", add_a, 0);
      checkOutput("add_cin_idle", add_cin, 0);
    end
    if (mPhase == 2) begin
      checkOutput("resp_sum", resp_sum, mRes[FW-1:0]);
      checkOutput("resp_cout", resp_cout, mRes[FW]);
      checkOutput("resp_id", resp_id, mId);
`ifdef ADD_SEQ_OVERFLOW_EN
      checkOutput("resp_ovf", resp_ovf,
                  (mOp.a[FW-1] == mOp.b[FW-1]) && (mRes[FW-1] != mOp.a[FW-1]));
`endif
    end else if (mPhase == 0) begin
      checkOutput("resp_sum_hold", resp_sum, mLastRes[FW-1:0]);
      checkOutput("resp_cout_hold", resp_cout, mLastRes[FW]);
    end
    @(posedge clk);
    case (mPhase)
      0: if (g0 || g1) begin
        mId = g1;
        mOp = g1 ? cur1 : cur0;
        mRes = {1'b0, mOp.a} + {1'b0, mOp.b} + wide_t'(mOp.cin);
        mLast = g1;
        if (g1) pres1 = 0;
        else    pres0 = 0;
        mK = 0;
        mPhase = 1;
      end
      1: begin
        mK++;
        if (mK == WORDS) mPhase = 2;
      end
      default: if (resp_ready) begin
        mLastRes = mRes;
        mPhase = 0;
      end
    endcase
  endtask

  task automatic runUntilIdle(input int maxCycles);
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || pres0 || pres1 || mPhase != 0) && n < maxCycles) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_bound", n < maxCycles, 1);
  endtask

  // Asynchronous reset asserted now; outputs must clear without waiting for a clock edge.
  task automatic resetNow();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_sum", resp_sum, 0);
    checkOutput("rst_resp_cout", resp_cout, 0);
    checkOutput("rst_resp_id", resp_id, 0);
    checkOutput("rst_req0_ready", req0_ready, 0);
    checkOutput("rst_add_a", add_a, 0);
    checkOutput("rst_add_cin", add_cin, 0);
`ifdef ADD_SEQ_OVERFLOW_EN
    checkOutput("rst_resp_ovf", resp_ovf, 0);
`endif
    mPhase = 0;
    mLast = 1;
    mLastRes = '0;
    pres0 = 0;
    pres1 = 0;
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [FW-1:0] ones;
    ones = '1;
    #2;
    resetNow();

    $display("[TB] single word carry into word 1");
    applyStimulus(0, FW'(32'hFFFF_FFFF), FW'(1), 1'b0);
    runUntilIdle(40);

    $display("[TB] carry ripples through all words");
    applyStimulus(1, ones, '0, 1'b1);
    runUntilIdle(40);

    $display("[TB] both requesters from reset, alternating");
    #2;
    resetNow();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, randWide(), randWide(), 1'($urandom_range(1)));
      applyStimulus(1, randWide(), randWide(), 1'($urandom_range(1)));
    end
    runUntilIdle(60);

    $display("[TB] response backpressure");
    applyStimulus(0, randWide(), randWide(), 1'b1);
    applyStimulus(0, randWide(), randWide(), 1'b0);
    readyMode = 2;
    for (int i = 0; i < 20 && mPhase != 2; i++) stepCycle();
    checkOutput("reach_done", mPhase == 2, 1);
    for (int i = 0; i < 5; i++) stepCycle();
    readyMode = 0;
    runUntilIdle(40);

    $display("[TB] reset in the middle of an addition");
    applyStimulus(0, randWide(), randWide(), 1'b1);
    for (int i = 0; i < 20 && !(mPhase == 1 && mK == 2); i++) stepCycle();
    checkOutput("reach_word2", (mPhase == 1) && (mK == 2), 1);
    #2;
    resetNow();
    for (int i = 0; i < 8; i++) stepCycle();
    applyStimulus(0, FW'(5), FW'(7), 1'b0);
    runUntilIdle(40);

`ifdef ADD_SEQ_OVERFLOW_EN
    $display("[TB] signed overflow cases");
    applyStimulus(0, {1'b0, ones[FW-2:0]}, FW'(1), 1'b0);
    applyStimulus(1, ones, FW'(1), 1'b0);
    runUntilIdle(60);
`endif

    $display("[TB] random traffic");
    presentPct = 60;
    readyMode = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0:       applyStimulus(1'($urandom_range(1)), ones, randWide(), 1'($urandom_range(1)));
        default: applyStimulus(1'($urandom_range(1)), randWide(), randWide(), 1'($urandom_range(1)));
      endcase
    end
    runUntilIdle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_share_sequencer.md
Name: adder_share_sequencer

Overview:
- Sequences multi-word additions through one shared external WIDTH-bit combinational adder (the team's carry-select adder) by chaining carry word-by-word, LSW first.
- Arbitrates round-robin between two requesters with valid/ready handshakes.
- Returns the full WIDTH*WORDS sum through a valid/ready response channel.
- Sits between the adder instance and its client blocks.

Parameters:
WIDTH, 32, bit width of the shared adder, one operand word
WORDS, 4, words per operand; full operand width is WIDTH*WORDS (WORDS >= 2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH*WORDS  requester 0 operand A
req0_b  in  WIDTH*WORDS  requester 0 operand B
req0_cin  in  1  requester 0 carry-in
req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
add_a  out  WIDTH  word to shared adder input a
add_b  out  WIDTH  word to shared adder input b
add_cin  out  1  carry to shared adder
add_sum  in  WIDTH  shared adder sum, combinational
add_cout  in  1  shared adder carry-out, combinational
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_sum  out  WIDTH*WORDS  full sum
resp_cout  out  1  carry out of the most significant word
resp_id  out  1  requester served (0/1)

Behaviour:
- Reset: rst_n asserted low, asynchronous, in any state.
  - Go to IDLE.
  - Clear operand, sum, carry and word-index registers.
  - last_grant = 1, so requester 0 wins the first tie.
  - resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0.
  - req0_ready=req1_ready=0; add_a=add_b=0, add_cin=0.
- Reset during RUN or DONE: the in-flight operation is discarded and no response is ever produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant logic is combinational:
    - Only one valid: grant that requester.
    - Both valid: grant the requester != last_grant.
  - reqN_ready = (state==IDLE) && rst_n && granted N. At most one ready is high per cycle.
  - On valid&&ready at an edge:
    - Capture a, b, cin and id; set last_grant=id.
    - Set word index k=0; go to RUN.
  - A requester not granted keeps waiting. Its valid must stay high, with inputs stable.
- RUN: one word per cycle, for k = 0..WORDS-1.
  - add_a = A[k*WIDTH +: WIDTH], add_b = B[k*WIDTH +: WIDTH].
  - add_cin = captured cin when k==0, otherwise the carry register.
  - Each edge: sum word k <= add_sum, carry <= add_cout, k <= k+1.
  - At k==WORDS-1: resp_cout <= add_cout, go to DONE.
- DONE:
  - resp_valid=1; resp_sum, resp_cout and resp_id are held stable until resp_ready.
  - On resp_valid&&resp_ready: go to IDLE, resp_valid=0.
- Outside RUN: add_a=add_b=0, add_cin=0.
- Timing:
  - Accept edge E; RUN occupies the WORDS cycles after E; resp_valid rises at edge E+WORDS.
  - Minimum issue interval is WORDS+2 cycles (IDLE, WORDS x RUN, DONE).
- Arithmetic:
  - Result is the exact (WIDTH*WORDS+1)-bit sum {resp_cout, resp_sum} = A + B + cin, modulo nothing.
  - Carry propagates across every word boundary.
- resp_ready high while not in DONE is ignored.
- resp_sum holds the last result until the next operation overwrites it word by word during RUN.

Optional Feature:
- Macro: ADD_SEQ_OVERFLOW_EN.
- Defined:
  - Extra output port resp_ovf (out, 1) = signed two's-complement overflow of the full-width add: (A msb == B msb) && (resp_sum msb != A msb).
  - Registered in the final RUN cycle and valid with resp_valid.
  - Reset value 0.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- req0 only, a=0x0..0_FFFFFFFF, b=0x1, cin=0 -> resp_sum=0x0..1_00000000, resp_cout=0, resp_id=0, resp_valid at accept edge +4 (WIDTH=32, WORDS=4).
- req1 a=all ones (128 bits), b=0, cin=1 -> resp_sum=0, resp_cout=1; add_cin observed 1 in every RUN cycle.
- req0 and req1 valid from first cycle after reset, resp_ready=1 -> service order 0,1,0,1; each gets its own correct sum and resp_id; one op per 6 cycles.
- Result pending with resp_ready low for 5 cycles while req0_valid=1 -> resp_valid and resp_sum stable, req0_ready=0 throughout; accepted only after the response handshake.
- rst_n low mid-RUN (k=2) -> resp_valid stays 0 and outputs clear immediately; after release, a=5, b=7, cin=0 -> resp_sum=12, resp_cout=0.
- ADD_SEQ_OVERFLOW_EN defined: a=0x7FFF..FF, b=1, cin=0 -> resp_ovf=1, resp_sum=0x8000..00; a=-1, b=1 -> resp_ovf=0, resp_cout=1.
